// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: size codes, FSM states and latency check shared by mem_bus_responder
package mem_bus_pkg;
   localparam logic [2:0] SZ_BYTE = 3'b001;
   localparam logic [2:0] SZ_HALF = 3'b010;
   localparam logic [2:0] SZ_WORD = 3'b100;
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_t;
   function automatic logic latency_ok(input int lat);
      return lat >= 1 && lat <= 7;
   endfunction
endpackage

// File: rtl/lane_unit.sv
// lane_unit: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lane_unit import mem_bus_pkg::*; (
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);
   logic [4:0]  sh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask;
   always_comb begin
      sh = size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
      b = 8'(word >> sh);
      h = 16'(word >> sh);
      load_val = size == SZ_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
                 size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word;
      mask = (size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      store_word = size == SZ_WORD ? wdata : (word & ~mask) | ((wdata << sh) & mask);
   end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: valid/ready load/store responder driving a fixed-latency word SRAM
module mem_bus_responder import mem_bus_pkg::*; #(
   parameter int ADDR_WIDTH   = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);
   localparam logic [2:0] LAT = 3'(latency_ok(READ_LATENCY) ? READ_LATENCY : 1);
   state_t                state_q, state_d;
   logic                  write_q, write_d, uns_q, uns_d;
   logic [2:0]            size_q, size_d, cnt_q, cnt_d;
   logic [1:0]            lane_q, lane_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  sram_en_q, sram_en_d, sram_we_q, sram_we_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [31:0]           sram_wdata_q, sram_wdata_d, resp_rdata_q, resp_rdata_d;
   logic                  resp_error_q, resp_error_d, req_err;
   logic [31:0]           load_val, store_word;

   lane_unit u_lane (
      .word(sram_rdata), .lane(lane_q), .size(size_q), .is_unsigned(uns_q),
      .wdata(wdata_q), .load_val(load_val), .store_word(store_word)
   );

   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;
   assign sram_en    = sram_en_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;

   always_comb begin
      req_err = !(req_size == SZ_BYTE || req_size == SZ_HALF || req_size == SZ_WORD) ||
                (req_size == SZ_HALF && req_addr[0]) ||
                (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      state_d      = state_q;
      write_d      = write_q;
      uns_d        = uns_q;
      size_d       = size_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      sram_en_d    = 1'b0;
      sram_we_d    = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      case (state_q)
         IDLE: if (req_valid) begin
            write_d      = req_write;
            uns_d        = req_unsigned;
            size_d       = req_size;
            lane_d       = req_addr[1:0];
            wdata_d      = req_wdata;
            sram_addr_d  = req_addr[ADDR_WIDTH+1:2];
            resp_rdata_d = 32'd0;
            resp_error_d = req_err;
            if (req_err) state_d = RESP;
            else if (req_write && req_size == SZ_WORD) begin
               state_d      = WRITE;
               sram_en_d    = 1'b1;
               sram_we_d    = 1'b1;
               sram_wdata_d = req_wdata;
            end else begin
               state_d   = RD_ISSUE;
               sram_en_d = 1'b1;
            end
         end
         RD_ISSUE: begin
            cnt_d   = LAT;
            state_d = RD_WAIT;
         end
         RD_WAIT: if (cnt_q == 3'd1) begin
            if (write_q) begin
               state_d      = WRITE;
               sram_en_d    = 1'b1;
               sram_we_d    = 1'b1;
               sram_wdata_d = store_word;
            end else begin
               state_d      = RESP;
               resp_rdata_d = load_val;
            end
         end else cnt_d = cnt_q - 3'd1;
         WRITE: state_d = RESP;
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= 3'd0;
         lane_q       <= 2'd0;
         wdata_q      <= 32'd0;
         cnt_q        <= 3'd0;
         sram_en_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         uns_q        <= uns_d;
         size_q       <= size_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         sram_en_q    <= sram_en_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed plus random requests checked against a shadow-memory reference model
module tb_mem_bus_responder;
   localparam int AW = 14;
   localparam int L  = 2;
   logic          clk = 1'b0, reset = 1'b1;
   logic          req_valid, req_ready, req_write, req_unsigned;
   logic [2:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_ready, resp_error;
   logic [31:0]   resp_rdata;
   logic          sram_en, sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata, sram_rdata;
   logic [31:0]   mem [0:63];
   logic [31:0]   ref_mem [0:63];
   logic [31:0]   pipe [0:L-1];
   logic          load_mem = 1'b0;
   int            n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // SRAM: junk on the read bus except exactly L cycles after a read strobe
   assign sram_rdata = pipe[L-1];
   always @(posedge clk) begin
      if (load_mem) for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
      else if (sram_en && sram_we) mem[sram_addr[5:0]] <= sram_wdata;
      pipe[0] <= (sram_en && !sram_we) ? mem[sram_addr[5:0]] : $urandom;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_req_ready"}, 32'(req_ready), 32'd1);
      check({p, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({p, "_resp_rdata"}, resp_rdata, 32'd0);
      check({p, "_resp_error"}, 32'(resp_error), 32'd0);
      check({p, "_sram_en"}, 32'(sram_en), 32'd0);
      check({p, "_sram_we"}, 32'(sram_we), 32'd0);
      check({p, "_sram_addr"}, 32'(sram_addr), 32'd0);
      check({p, "_sram_wdata"}, sram_wdata, 32'd0);
   endtask

   task automatic do_req(input logic w, input logic [2:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic bp);
      logic        e_err, got_e;
      logic [31:0] e_data, e_wd, got_d, wd_at;
      int          e_lat, e_en, e_we, lat, en_n, we_at, bits, off, idx, ad_at;
      longint      raw, mk, old;
      e_err  = !(sz == 3'd1 || sz == 3'd2 || sz == 3'd4) || (sz == 3'd2 && a[0]) ||
               (sz == 3'd4 && a[1:0] != 2'd0) || a[31:AW+2] != 0;
      e_data = 32'd0;
      e_wd   = 32'd0;
      idx    = int'(a[AW+1:2]);
      e_lat  = e_err ? 1 : (w && sz == 3'd4) ? 2 : w ? 3 + L : 2 + L;
      e_en   = e_err ? 0 : (w && sz != 3'd4) ? 2 : 1;
      e_we   = (e_err || !w) ? 0 : sz == 3'd4 ? 1 : 2 + L;
      if (!e_err) begin
         bits = 8 * int'(sz);
         off  = 8 * int'(a[1:0]);
         mk   = (64'sd1 <<< bits) - 1;
         old  = longint'({32'd0, ref_mem[idx]});
         if (!w) begin
            raw = (old >>> off) & mk;
            if (!u && raw >= (64'sd1 <<< (bits - 1))) raw = raw - (64'sd1 <<< bits);
            e_data = 32'(raw);
         end else begin
            e_wd = 32'((old & ~(mk <<< off)) | ((longint'({32'd0, d}) & mk) <<< off));
            ref_mem[idx] = e_wd;
         end
      end
      @(negedge clk);
      check("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d; resp_ready = !bp;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = $urandom; req_size = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; en_n = 0; we_at = 0; wd_at = 32'd0; ad_at = 0; got_d = 32'd0; got_e = 1'b0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (sram_en) begin
            en_n++;
            ad_at = int'(sram_addr);
            if (sram_we) begin
               we_at = k;
               wd_at = sram_wdata;
            end
         end
         if (resp_valid) begin
            lat = k;
            got_d = resp_rdata;
            got_e = resp_error;
         end
      end
      check("latency", 32'(lat), 32'(e_lat));
      check("sram_en_count", 32'(en_n), 32'(e_en));
      check("write_cycle", 32'(we_at), 32'(e_we));
      check("resp_rdata", got_d, e_data);
      check("resp_error", 32'(got_e), 32'(e_err));
      if (!e_err) check("sram_addr", 32'(ad_at), 32'(idx));
      if (w && !e_err) check("sram_wdata", wd_at, e_wd);
      if (bp) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, got_d);
            check("hold_error", 32'(resp_error), 32'(got_e));
            check("hold_req_ready", 32'(req_ready), 32'd0);
         end
         resp_ready = 1'b1;
      end
   endtask

   initial begin
      logic        we_seen;
      logic [2:0]  sz;
      logic [31:0] a;
      req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
      load_mem = 1'b1;
      repeat (3) @(posedge clk);
      load_mem = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      do_req(1'b1, 3'd4, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      do_req(1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b1, 3'd4, 1'b0, 32'h10, 32'h11223344, 1'b0);
      do_req(1'b1, 3'd1, 1'b0, 32'h12, 32'h000000AB, 1'b0);
      do_req(1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b0);
      check("byte_merge_ref", ref_mem[4], 32'h11AB3344);
      do_req(1'b1, 3'd4, 1'b0, 32'h10, 32'h80FF7F01, 1'b0);
      do_req(1'b0, 3'd1, 1'b0, 32'h13, 32'h0, 1'b0);
      do_req(1'b0, 3'd1, 1'b1, 32'h13, 32'h0, 1'b0);
      do_req(1'b0, 3'd2, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 3'd2, 1'b0, 32'h12, 32'h0, 1'b0);
      do_req(1'b0, 3'd4, 1'b0, 32'h11, 32'h0, 1'b0);
      do_req(1'b1, 3'd2, 1'b0, 32'h13, 32'h5555, 1'b0);
      do_req(1'b0, 3'b011, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 3'd4, 1'b0, 32'h0001_0000, 32'h0, 1'b0);
      do_req(1'b0, 3'd2, 1'b1, 32'h12, 32'h0, 1'b1);
      do_req(1'b0, 3'd4, 1'b0, 32'h13, 32'h0, 1'b1);

      // abort a sub-word store while it waits on read data
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 3'd1; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h0000005A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      we_seen = 1'b0;
      @(negedge clk);
      we_seen = we_seen | (sram_en & sram_we);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("abort");
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         we_seen = we_seen | sram_en | resp_valid;
      end
      check("abort_no_activity", 32'(we_seen), 32'd0);
      do_req(1'b0, 3'd4, 1'b0, 32'h20, 32'h0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
